// File: rtl/reprodutor_sequencia.sv
// Plays the stored move sequence (positions 0..rodada) on the LEDs.
// For each move: one cycle reading memory, then T_ACESO cycles lit, then T_APAGADO cycles dark.
module reprodutor_sequencia #(
    parameter int T_ACESO    = 5000,
    parameter int T_APAGADO  = 2500,
    parameter int N_ENDERECO = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [N_ENDERECO-1:0] rodada,
    input  logic [3:0]            mem_dado,
    output logic [N_ENDERECO-1:0] mem_endereco,
    output logic [3:0]            leds,
    output logic                  ocupado,
    output logic                  pronto,
    output logic [2:0]            db_estado
);
    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        LE_MEMORIA = 3'd1,
        ACESO      = 3'd2,
        APAGADO    = 3'd3,
        FIM        = 3'd4
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_ENDERECO-1:0] rodada_q, rodada_d;
    logic [N_ENDERECO-1:0] endereco_q, endereco_d;
    logic [3:0]            leds_q, leds_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            cnt_q      <= '0;
            rodada_q   <= '0;
            endereco_q <= '0;
            leds_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        case (estado_q)
            INICIAL: begin
                // Address keeps its last value while idle; cleared only on a new start.
                if (iniciar) begin
                    rodada_d   = rodada;
                    endereco_d = '0;
                    cnt_d      = '0;
                    estado_d   = LE_MEMORIA;
                end
            end
            LE_MEMORIA: begin
                leds_d   = mem_dado;
                cnt_d    = '0;
                estado_d = ACESO;
            end
            ACESO: begin
                if (cnt_q == CW'(T_ACESO - 1)) begin
                    leds_d   = '0;
                    cnt_d    = '0;
                    estado_d = APAGADO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APAGADO: begin
                if (cnt_q == CW'(T_APAGADO - 1)) begin
                    cnt_d = '0;
                    if (endereco_q == rodada_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + N_ENDERECO'(1);
                        estado_d   = LE_MEMORIA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    assign mem_endereco = endereco_q;
    assign leds         = leds_q;
    assign ocupado      = (estado_q != INICIAL);
    assign pronto       = (estado_q == FIM);
    assign db_estado    = estado_q;
endmodule

// File: tb/tb_reprodutor_sequencia.sv
// Bench for reprodutor_sequencia: directed steps plus random runs, checked every cycle
// against a timeline model (edges since start -> move index and phase).
module tb_reprodutor_sequencia;
    localparam int TA = 3;
    localparam int TP = 2;
    localparam int P  = 1 + TA + TP;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] rodada = '0;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado, pronto;
    logic [2:0] db_estado;

    logic [3:0] mem [16];
    int checks = 0;
    int failures = 0;

    // Model: running flag, edges since accepting start, latched rodada, idle address.
    bit m_run = 1'b0;
    int m_j = 0;
    int m_r = 0;
    int m_addr = 0;

    assign mem_dado = mem[mem_endereco];

    reprodutor_sequencia #(.T_ACESO(TA), .T_APAGADO(TP), .N_ENDERECO(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .rodada(rodada),
        .mem_dado(mem_dado), .mem_endereco(mem_endereco), .leds(leds),
        .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        int m, ph;
        logic [2:0] e_st;
        logic [3:0] e_leds;
        int e_addr;
        logic e_oc, e_pr;
        @(posedge clock);
        if (reset) begin
            m_run = 1'b0; m_addr = 0;
        end else if (!m_run) begin
            if (iniciar) begin
                m_run = 1'b1; m_j = 0; m_r = int'(rodada); m_addr = 0;
            end
        end else begin
            m_j++;
            if (m_j > (m_r + 1) * P) begin
                m_run = 1'b0; m_addr = m_r;
            end
        end
        @(negedge clock);
        e_leds = 4'b0000; e_pr = 1'b0; e_oc = 1'b1;
        if (!m_run) begin
            e_st = 3'd0; e_addr = m_addr; e_oc = 1'b0;
        end else if (m_j == (m_r + 1) * P) begin
            e_st = 3'd4; e_addr = m_r; e_pr = 1'b1;
        end else begin
            m = m_j / P; ph = m_j % P; e_addr = m;
            if (ph == 0) e_st = 3'd1;
            else if (ph <= TA) begin e_st = 3'd2; e_leds = mem[m]; end
            else e_st = 3'd3;
        end
        chk("leds", {4'b0, leds}, {4'b0, e_leds});
        chk("mem_endereco", {4'b0, mem_endereco}, 8'(e_addr));
        chk("ocupado", {7'b0, ocupado}, {7'b0, e_oc});
        chk("pronto", {7'b0, pronto}, {7'b0, e_pr});
        chk("db_estado", {5'b0, db_estado}, {5'b0, e_st});
    endtask

    initial begin
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
        mem[4] = 4'b0100; mem[5] = 4'b0010; mem[6] = 4'b0001; mem[7] = 4'b0001;
        for (int i = 8; i < 16; i++) mem[i] = 4'($urandom);

        // 1: reset
        @(negedge clock);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 2: single move
        rodada = 4'd0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (10) tick();

        // 3: four moves
        rodada = 4'd3; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (26) tick();

        // 4: iniciar held, rodada changed mid-sequence, auto restart with new rodada
        rodada = 4'd2; iniciar = 1'b1;
        repeat (8) tick();
        rodada = 4'd7;
        repeat (13) tick();
        iniciar = 1'b0;
        repeat (52) tick();

        // 5: reset during ACESO of move 1, then a normal short sequence
        rodada = 4'd3; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        rodada = 4'd0; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (8) tick();

        // 6: full sequence, address stops at 15
        rodada = 4'd15; iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (100) tick();

        // Random runs: random memory, rodada, start width and input noise mid-sequence
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
            rodada = 4'($urandom); iniciar = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            iniciar = 1'b0;
            for (int c = 0; c < 100; c++) begin
                rodada = 4'($urandom);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
